regfile_wb_arbiter: RTL

//  Shares the single register-file write port (d/rd/rwe) among NREQ writeback

---
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the single regfile write port
// (d/rd/rwe) among NREQ writeback requesters using valid/ready handshakes.
// Optional build macro REGFILE_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins, ptr tied to 0); default is round-robin.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 16,
  localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        d,
  output logic [DW-1:0]        rd,
  output logic                 rwe,
  output logic [CNTW-1:0]      wr_count,
  output logic [PW-1:0]        ptr
);

  logic            found;
  logic [PW-1:0]   gnt_idx;
  logic [PW-1:0]   cand_idx;
  logic [NREQ-1:0] grant;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;
  logic            xfer;
  int              cand;

  // Search valid requests starting at ptr, wrapping; grant the first one found.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    cand     = 0;
    grant    = '0;
    if (!reset && !stall) begin
      for (int off = 0; off < int'(NREQ); off++) begin
        cand     = (int'(ptr) + off) % int'(NREQ);
        cand_idx = PW'(cand);
        if (!found && req_valid[cand_idx]) begin
          found   = 1'b1;
          gnt_idx = cand_idx;
        end
      end
      if (found) grant = NREQ'(1) << gnt_idx;
    end
  end

  // Route the winner's address/data toward the write-port registers.
  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        gnt_addr = req_addr[i*AW +: AW];
        gnt_data = req_data[i*DW +: DW];
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  // Register the write port, transfer counter and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      rwe      <= 1'b0;
      d        <= '0;
      rd       <= '0;
      wr_count <= '0;
      ptr      <= '0;
    end else begin
      // Writes to address 0 are accepted and counted but never enabled.
      rwe <= xfer && (gnt_addr != '0);
      if (xfer) begin
        d        <= gnt_addr;
        rd       <= gnt_data;
        wr_count <= wr_count + CNTW'(1);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        ptr      <= '0;
`else
        ptr      <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
`endif
      end
    end
  end

endmodule
